// File: rtl/sc_dmem_io_if.sv
// CPU data-port bus for sc_dmem_io: byte address, store data, store enable and load data.
interface sc_dmem_io_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [31:0] dataout;

  modport master (output addr, output datain, output we, input dataout);
  modport slave  (input addr, input datain, input we, output dataout);
endinterface

// File: rtl/sc_dmem_io.sv
// Data memory and memory-mapped I/O responder for a single-cycle CPU (zero-latency reads).
// Optional timer block (TCOUNT/TCMP/STATUS) is built only when SC_DMEM_TIMER_EN is defined.
module sc_dmem_io #(
  parameter int ADDR_WIDTH = 10,
  parameter int SW_WIDTH   = 10,
  parameter int KEY_WIDTH  = 4,
  parameter int LED_WIDTH  = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  sc_dmem_io_if.slave          bus,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam logic [5:0] OFF_SW     = 6'h00;
  localparam logic [5:0] OFF_KEYCAP = 6'h01;
  localparam logic [5:0] OFF_LED    = 6'h02;
`ifdef SC_DMEM_TIMER_EN
  localparam logic [5:0] OFF_TCOUNT = 6'h03;
  localparam logic [5:0] OFF_TCMP   = 6'h04;
  localparam logic [5:0] OFF_STATUS = 6'h05;
`endif

  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [SW_WIDTH-1:0]   r_sw_s1, r_sw_s2;
  logic [KEY_WIDTH-1:0]  r_key_s1, r_key_s2, r_key_d;
  logic [KEY_WIDTH-1:0]  r_keycap;
  logic [LED_WIDTH-1:0]  r_led;

  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic [5:0]            w_off;
  logic                  w_io_we;
  logic [KEY_WIDTH-1:0]  w_key_rise;
  logic [KEY_WIDTH-1:0]  w_key_clr;

  assign w_ram_idx  = bus.addr[ADDR_WIDTH+1:2];
  assign w_off      = bus.addr[7:2];
  assign w_io_we    = bus.we & bus.addr[31];
  assign w_key_rise = r_key_s2 & ~r_key_d;
  assign w_key_clr  = (w_io_we && w_off == OFF_KEYCAP) ? bus.datain[KEY_WIDTH-1:0] : '0;
  assign led_out    = r_led;

  // RAM has no reset; writes are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (bus.we && !bus.addr[31] && !reset)
      r_mem[w_ram_idx] <= bus.datain;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_key_d  <= '0;
      r_keycap <= '0;
      r_led    <= '0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= key_in;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      // New edges are OR-ed in after the clear so a coincident capture survives.
      r_keycap <= (r_keycap & ~w_key_clr) | w_key_rise;
      if (w_io_we && w_off == OFF_LED)
        r_led <= bus.datain[LED_WIDTH-1:0];
    end
  end

`ifdef SC_DMEM_TIMER_EN
  logic [31:0] r_tcount, r_tcmp;
  logic        r_status;
  logic        w_st_clr;

  assign w_st_clr = w_io_we && w_off == OFF_STATUS && bus.datain[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tcount <= '0;
      r_tcmp   <= '0;
      r_status <= 1'b0;
    end else begin
      if (w_io_we && w_off == OFF_TCOUNT)
        r_tcount <= bus.datain;
      else
        r_tcount <= r_tcount + 32'd1;
      if (w_io_we && w_off == OFF_TCMP)
        r_tcmp <= bus.datain;
      r_status <= (r_tcount == r_tcmp) | (r_status & ~w_st_clr);
    end
  end
`endif

  always_comb begin
    bus.dataout = '0;
    if (!bus.addr[31]) begin
      bus.dataout = r_mem[w_ram_idx];
    end else begin
      case (w_off)
        OFF_SW:     bus.dataout = {{(32-SW_WIDTH){1'b0}}, r_sw_s2};
        OFF_KEYCAP: bus.dataout = {{(32-KEY_WIDTH){1'b0}}, r_keycap};
        OFF_LED:    bus.dataout = {{(32-LED_WIDTH){1'b0}}, r_led};
`ifdef SC_DMEM_TIMER_EN
        OFF_TCOUNT: bus.dataout = r_tcount;
        OFF_TCMP:   bus.dataout = r_tcmp;
        OFF_STATUS: bus.dataout = {31'd0, r_status};
`endif
        default:    bus.dataout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_dmem_io.sv
// Directed bench for sc_dmem_io: behavioural model checked every cycle plus literal expectations.
module tb_sc_dmem_io;
  localparam int AW = 10;
  localparam logic [31:0] A_SW     = 32'h8000_0000;
  localparam logic [31:0] A_KEYCAP = 32'h8000_0004;
  localparam logic [31:0] A_LED    = 32'h8000_0008;
  localparam logic [31:0] A_TCOUNT = 32'h8000_000C;
  localparam logic [31:0] A_TCMP   = 32'h8000_0010;
  localparam logic [31:0] A_STATUS = 32'h8000_0014;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] sw_in;
  logic [3:0] key_in;
  logic [9:0] led_out;
  int         total = 0;
  int         bad   = 0;

  sc_dmem_io_if bus ();

  sc_dmem_io #(.ADDR_WIDTH(AW), .SW_WIDTH(10), .KEY_WIDTH(4), .LED_WIDTH(10)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .sw_in   (sw_in),
    .key_in  (key_in),
    .led_out (led_out)
  );

  always #5 clock = ~clock;

  // Model state: spec-level quantities, sampled-input histories and a sparse RAM.
  logic [31:0] m_ram [int];
  logic [9:0]  m_sw_now = '0, m_sw_prev = '0;
  logic [3:0]  m_k0 = '0, m_k1 = '0, m_k2 = '0;
  logic [3:0]  m_keycap = '0;
  logic [9:0]  m_led = '0;
  logic [31:0] m_tc = '0, m_tcmp = '0;
  logic        m_st = 1'b0;

  always @(posedge clock or posedge reset) begin
    logic       wr;
    logic [5:0] off;
    logic       match;
    if (reset) begin
      m_sw_now = '0; m_sw_prev = '0;
      m_k0 = '0; m_k1 = '0; m_k2 = '0;
      m_keycap = '0; m_led = '0;
      m_tc = '0; m_tcmp = '0; m_st = 1'b0;
    end else begin
      wr  = bus.we && bus.addr[31];
      off = bus.addr[7:2];
      if (bus.we && !bus.addr[31])
        m_ram[int'(bus.addr[AW+1:2])] = bus.datain;
      // a key level seen two samples ago, absent three samples ago, is a fresh press
      m_keycap = (m_keycap & ~((wr && off == 6'd1) ? bus.datain[3:0] : 4'h0)) | (m_k1 & ~m_k2);
      m_k2 = m_k1; m_k1 = m_k0; m_k0 = key_in;
      m_sw_prev = m_sw_now; m_sw_now = sw_in;
      if (wr && off == 6'd2) m_led = bus.datain[9:0];
      match = (m_tc == m_tcmp);
      m_tc = (wr && off == 6'd3) ? bus.datain : m_tc + 32'd1;
      if (wr && off == 6'd4) m_tcmp = bus.datain;
      m_st = match | (m_st & !(wr && off == 6'd5 && bus.datain[0]));
    end
  end

  function automatic logic [31:0] model_rd(input logic [31:0] a, output bit known);
    known = 1'b1;
    if (!a[31]) begin
      if (m_ram.exists(int'(a[AW+1:2]))) return m_ram[int'(a[AW+1:2])];
      known = 1'b0;
      return 32'h0;
    end
    case (a[7:2])
      6'd0: return {22'd0, m_sw_prev};
      6'd1: return {28'd0, m_keycap};
      6'd2: return {22'd0, m_led};
`ifdef SC_DMEM_TIMER_EN
      6'd3: return m_tc;
      6'd4: return m_tcmp;
      6'd5: return {31'd0, m_st};
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    bit          known;
    logic [31:0] e;
    e = model_rd(bus.addr, known);
    if (known) check("model_dataout", bus.dataout, e);
    check("model_led_out", {22'd0, led_out}, {22'd0, m_led});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.datain = d; bus.we = 1'b1;
    step();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a; bus.we = 1'b0;
    #1;
    check(name, bus.dataout, exp);
  endtask

  initial begin
    reset = 1'b1; sw_in = '0; key_in = '0;
    bus.addr = '0; bus.datain = '0; bus.we = 1'b0;
    repeat (3) step();
    check("rst_led_out", {22'd0, led_out}, 32'h0);
    rd_chk("rst_sw", A_SW, 32'h0);
    rd_chk("rst_keycap", A_KEYCAP, 32'h0);
    wr(A_LED, 32'h155);
    rd_chk("rst_led_write_ignored", A_LED, 32'h0);
    reset = 1'b0;
    step();

    // RAM write/read, read-before-write, aliasing
    wr(32'h10, 32'hAAAA_5555);
    bus.addr = 32'h10; bus.datain = 32'h1234_5678; bus.we = 1'b1;
    #1;
    check("ram_old_data", bus.dataout, 32'hAAAA_5555);
    step();
    bus.we = 1'b0;
    wr(32'h14, 32'hDEAD_BEEF);
    rd_chk("ram_0x10", 32'h10, 32'h1234_5678);
    rd_chk("ram_0x14", 32'h14, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h10 + (32'd4 << AW), 32'h1234_5678);

    // switch synchroniser latency
    sw_in = 10'h2A5; bus.addr = A_SW;
    step();
    rd_chk("sw_after1", A_SW, 32'h0);
    step();
    rd_chk("sw_after2", A_SW, 32'h2A5);

    // key pulse capture, sticky, W1C
    key_in[2] = 1'b1; bus.addr = A_KEYCAP;
    step(); rd_chk("key_e1", A_KEYCAP, 32'h0);
    step(); rd_chk("key_e2", A_KEYCAP, 32'h0);
    step(); rd_chk("key_e3", A_KEYCAP, 32'h4);
    step(); step();
    key_in[2] = 1'b0;
    repeat (3) step();
    rd_chk("key_sticky", A_KEYCAP, 32'h4);
    wr(A_KEYCAP, 32'h4);
    rd_chk("key_w1c", A_KEYCAP, 32'h0);
    key_in[2] = 1'b1;
    step(); step();
    wr(A_KEYCAP, 32'h4);
    rd_chk("key_set_wins", A_KEYCAP, 32'h4);
    key_in[2] = 1'b0;

    // LED register
    wr(A_LED, 32'hFFFF_F3FF);
    check("led_out_3ff", {22'd0, led_out}, 32'h3FF);
    rd_chk("led_rd", A_LED, 32'h3FF);

    // unmapped offset
    rd_chk("unmapped_rd", 32'h8000_0020, 32'h0);
    wr(32'h8000_0020, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd2", 32'h8000_0020, 32'h0);
    rd_chk("unmapped_led_kept", A_LED, 32'h3FF);
    rd_chk("unmapped_key_kept", A_KEYCAP, 32'h4);

`ifdef SC_DMEM_TIMER_EN
    wr(A_TCMP, 32'd20);
    wr(A_TCOUNT, 32'd15);
    wr(A_STATUS, 32'h1);
    for (int i = 2; i <= 6; i++) begin
      step();
      rd_chk($sformatf("status_edge%0d", i), A_STATUS, (i == 6) ? 32'h1 : 32'h0);
    end
    wr(A_STATUS, 32'h1);
    rd_chk("status_cleared", A_STATUS, 32'h0);
    wr(A_TCOUNT, 32'hFFFF_FFFF);
    rd_chk("tcount_loaded", A_TCOUNT, 32'hFFFF_FFFF);
    step();
    rd_chk("tcount_wrap", A_TCOUNT, 32'h0);
`else
    for (int i = 0; i < 3; i++) begin
      rd_chk("no_timer_tcount", A_TCOUNT, 32'h0);
      step();
    end
    wr(A_TCOUNT, 32'h5);
    rd_chk("no_timer_tcount_wr", A_TCOUNT, 32'h0);
    rd_chk("no_timer_tcmp", A_TCMP, 32'h0);
    rd_chk("no_timer_status", A_STATUS, 32'h0);
`endif

    // asynchronous reset mid-run, key held across release
    key_in[0] = 1'b1;
    bus.addr = A_LED;
    reset = 1'b1;
    #1;
    check("async_rst_led_out", {22'd0, led_out}, 32'h0);
    check("async_rst_led_rd", bus.dataout, 32'h0);
    rd_chk("async_rst_keycap", A_KEYCAP, 32'h0);
    step(); step();
    reset = 1'b0;
    step(); rd_chk("held_key_e1", A_KEYCAP, 32'h0);
    step(); rd_chk("held_key_e2", A_KEYCAP, 32'h0);
    step(); rd_chk("held_key_e3", A_KEYCAP, 32'h1);
    repeat (3) step();
    rd_chk("held_key_once", A_KEYCAP, 32'h1);
    rd_chk("ram_survives_reset", 32'h14, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sc_dmem_io.md
Name: sc_dmem_io

Overview:
- Data-side responder for the single-cycle CPU's load/store interface.
- Accepts the CPU's byte address (ALU result), store data, and write-enable. Returns read data in the same cycle, as a single-cycle datapath requires.
- Decodes the address into a word RAM or a small memory-mapped I/O page: synchronized switches, key edge-capture, LED register and a free-running timer.
- Sits between the CPU's data port and the board I/O, alongside the instruction memory.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; RAM holds 2**ADDR_WIDTH 32-bit words.
- SW_WIDTH, 10, switch input width.
- KEY_WIDTH, 4, key input width.
- LED_WIDTH, 10, LED output width.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  byte address from CPU ALU output.
- datain  input  32  store data from CPU register read port b.
- we  input  1  store enable from CPU (wmem).
- dataout  output  32  load data to CPU (mem); combinational from addr and current state.
- sw_in  input  SW_WIDTH  asynchronous board switches.
- key_in  input  KEY_WIDTH  asynchronous board keys; 1 = pressed.
- led_out  output  LED_WIDTH  LED register contents.

Behaviour:
- Decode: addr[31]=0 selects RAM; addr[31]=1 selects the I/O page, offset addr[7:2]. addr[1:0] ignored (word access only). RAM index = addr[ADDR_WIDTH+1:2]; upper RAM address bits ignored, so the RAM aliases.
- RAM read: asynchronous, zero latency. RAM write: datain stored at the rising edge when we=1. A read of the address being written returns old data until that edge.
- RAM is not cleared by reset.
- I/O map:
  - 0x80000000 SW: read-only, zero-extended 2-flop-synchronized sw_in.
  - 0x80000004 KEYCAP: one sticky bit per key, set on a synchronized rising edge. A write clears each bit where datain is 1 (W1C). If set and clear hit the same bit in the same cycle, set wins.
  - 0x80000008 LED: read/write, LED_WIDTH bits. A write takes datain[LED_WIDTH-1:0]; reads are zero-extended. Drives led_out directly.
  - 0x8000000C TCOUNT: increments by 1 every cycle and wraps 0xFFFFFFFF->0x00000000. A write loads datain, with no increment that cycle.
  - 0x80000010 TCMP: read/write compare value.
  - 0x80000014 STATUS: bit0 = timer match, sticky. Set at the edge after any cycle where TCOUNT==TCMP. A write with datain[0]=1 clears it; set wins over a simultaneous clear. Bits 31:1 read 0.
- Any other I/O offset reads 0; writes are ignored.
- Latency:
  - sw_in change is visible in the SW read after 2 rising edges.
  - A key rising edge is visible in KEYCAP after 3 rising edges (sync1, sync2, compare against the delayed copy).
- Reset values: led_out=0, TCOUNT=0, TCMP=0, STATUS=0, KEYCAP=0, all sync and delay flops=0. dataout reflects these values during reset.
- Reset asserted mid-operation clears all I/O state immediately. Writes presented while reset=1 are ignored for I/O; the RAM write is also suppressed while reset=1.
- A key already held when reset releases produces one capture, because the delayed copy starts at 0.

Optional Feature:
- Macro: SC_DMEM_TIMER_EN.
- Defined: TCOUNT, TCMP and STATUS registers exist exactly as described above.
- Not defined: no timer logic is built. Offsets 0x0C, 0x10 and 0x14 read 0 and ignore writes; all other behaviour is unchanged.

Test Plan:
- Reset, then write 0x12345678 to 0x00000010 and 0xDEADBEEF to 0x00000014 -> reads return each value. A read of 0x00000010 in the same cycle as its write shows the old contents. Address 0x00000010+(4<<ADDR_WIDTH) aliases to 0x12345678.
- sw_in=0x2A5 -> SW read returns 0x000002A5 after exactly 2 edges, and still the old value after 1 edge.
- Pulse key_in[2] high for 5 cycles -> KEYCAP=0x4 from the 3rd edge and stays set after release. Write 0x4 -> reads 0. Key edge coinciding with the clearing write -> bit remains 1.
- Write 0x3FF to LED -> led_out=0x3FF and the read returns 0x000003FF. Assert reset mid-run -> led_out=0 immediately, without waiting for a clock edge.
- (TIMER_EN) Write TCMP=20, TCOUNT=15 -> STATUS=1 six edges after the TCOUNT write. Write 1 to STATUS -> 0. Load TCOUNT=0xFFFFFFFF -> reads 0x00000000 one cycle later.
- Read 0x80000020 and write to it -> reads 0, no state change. Without SC_DMEM_TIMER_EN, 0x8000000C reads 0 across cycles.
